// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - bus bundle between the VDC and the VRAM arbiter
// DMA signals exist only when VRAM_ARB_DMA_EN is defined.
interface vram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [2:0]        char_cycle;
    logic              bg_active;
    logic [ADDR_W-1:0] bg_addr;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_busy;
    logic              cpu_ovf;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic [ADDR_W-1:0] vram_addr;
    logic              vram_re;
    logic              vram_we;
    logic [DATA_W-1:0] vram_wdata;
    logic [DATA_W-1:0] vram_rdata;
`ifdef VRAM_ARB_DMA_EN
    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_rvalid;
`endif

    modport slave (
`ifdef VRAM_ARB_DMA_EN
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rdata, dma_rvalid,
`endif
        input  char_cycle, bg_active, bg_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_busy, cpu_ovf, cpu_rdata, cpu_rvalid,
        output vram_addr, vram_re, vram_we, vram_wdata,
        input  vram_rdata
    );

    modport master (
`ifdef VRAM_ARB_DMA_EN
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rdata, dma_rvalid,
`endif
        output char_cycle, bg_active, bg_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_busy, cpu_ovf, cpu_rdata, cpu_rvalid,
        input  vram_addr, vram_re, vram_we, vram_wdata,
        output vram_rdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM slot arbiter (BG > CPU > DMA)
// Optional DMA requester is enabled with VRAM_ARB_DMA_EN.
module vram_arbiter #(
    parameter int          ADDR_W       = 16,
    parameter int          DATA_W       = 16,
    parameter logic [7:0]  BG_SLOT_MASK = 8'b1010_0010
) (
    input  logic          clock,
    input  logic          reset,
    vram_arbiter_if.slave bus
);

    logic              bg_slot;
    logic              cpu_gnt;
    logic              accept;

    logic              pend_q, pend_d;
    logic              pwe_q, pwe_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              ovf_q, ovf_d;
    logic              tag_cpu_q, tag_cpu_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef VRAM_ARB_DMA_EN
    logic              dma_gnt;
    logic              tag_dma_q, tag_dma_d;
    logic              dma_rvalid_q, dma_rvalid_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
`endif

    assign bg_slot = bus.bg_active && BG_SLOT_MASK[bus.char_cycle];
    assign cpu_gnt = pend_q && !bg_slot;
    // Acceptance looks only at the registered buffer, so a request arriving in G is dropped.
    assign accept  = bus.cpu_req && !pend_q;
`ifdef VRAM_ARB_DMA_EN
    // A CPU strobe arriving in a free cycle still outranks DMA; it is served next cycle.
    assign dma_gnt = bus.dma_req && !bg_slot && !pend_q && !bus.cpu_req;
`endif

    always_comb begin
        bus.vram_addr  = '0;
        bus.vram_re    = 1'b0;
        bus.vram_we    = 1'b0;
        bus.vram_wdata = '0;
        if (bg_slot) begin
            bus.vram_addr = bus.bg_addr;
            bus.vram_re   = 1'b1;
        end else if (cpu_gnt) begin
            bus.vram_addr  = paddr_q;
            bus.vram_re    = !pwe_q;
            bus.vram_we    = pwe_q;
            bus.vram_wdata = pwdata_q;
        end
`ifdef VRAM_ARB_DMA_EN
        else if (dma_gnt) begin
            bus.vram_addr  = bus.dma_addr;
            bus.vram_re    = !bus.dma_we;
            bus.vram_we    = bus.dma_we;
            bus.vram_wdata = bus.dma_wdata;
        end
`endif
    end

    always_comb begin
        pend_d   = pend_q;
        pwe_d    = pwe_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        if (cpu_gnt) begin
            pend_d = 1'b0;
        end
        if (accept) begin
            pend_d   = 1'b1;
            pwe_d    = bus.cpu_we;
            paddr_d  = bus.cpu_addr;
            pwdata_d = bus.cpu_wdata;
        end
        ovf_d     = ovf_q || (bus.cpu_req && pend_q);
        tag_cpu_d = cpu_gnt && !pwe_q;
        rvalid_d  = tag_cpu_q;
        rdata_d   = tag_cpu_q ? bus.vram_rdata : rdata_q;
`ifdef VRAM_ARB_DMA_EN
        tag_dma_d    = dma_gnt && !bus.dma_we;
        dma_rvalid_d = tag_dma_q;
        dma_rdata_d  = tag_dma_q ? bus.vram_rdata : dma_rdata_q;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_q       <= 1'b0;
            pwe_q        <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            ovf_q        <= 1'b0;
            tag_cpu_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
`ifdef VRAM_ARB_DMA_EN
            tag_dma_q    <= 1'b0;
            dma_rvalid_q <= 1'b0;
            dma_rdata_q  <= '0;
`endif
        end else begin
            pend_q       <= pend_d;
            pwe_q        <= pwe_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            ovf_q        <= ovf_d;
            tag_cpu_q    <= tag_cpu_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
`ifdef VRAM_ARB_DMA_EN
            tag_dma_q    <= tag_dma_d;
            dma_rvalid_q <= dma_rvalid_d;
            dma_rdata_q  <= dma_rdata_d;
`endif
        end
    end

    assign bus.cpu_busy   = pend_q;
    assign bus.cpu_ovf    = ovf_q;
    assign bus.cpu_rvalid = rvalid_q;
    assign bus.cpu_rdata  = rdata_q;
`ifdef VRAM_ARB_DMA_EN
    assign bus.dma_gnt    = dma_gnt;
    assign bus.dma_rvalid = dma_rvalid_q;
    assign bus.dma_rdata  = dma_rdata_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - randomized bench for vram_arbiter with a slot-level reference model
module tb_vram_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    vram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    vram_arbiter #(
        .ADDR_W(16),
        .DATA_W(16),
        .BG_SLOT_MASK(8'b1010_0010)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        int          due;
        logic [15:0] d;
    } rd_t;

    logic [7:0]  bg_mask = 8'b1010_0010;
    logic [15:0] vmem    [0:65535];
    logic [15:0] ref_mem [0:65535];

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [2:0]  cc       = 3'd0;

    bit          m_pend, m_we, m_ovf;
    logic [15:0] m_addr, m_wdata, m_rdata;
    rd_t         rq[$];

    logic [15:0] last_addr, last_wdata, last_rdata;
    logic        last_re, last_we, last_rvalid, last_ovf, last_busy;
    logic [2:0]  last_cc;

    always @(posedge clock) begin
        if (bus.vram_re) bus.vram_rdata <= vmem[bus.vram_addr];
        if (bus.vram_we) vmem[bus.vram_addr] <= bus.vram_wdata;
    end

    function automatic logic [15:0] init_val(logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic idle_in();
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.bg_active = 1'b0;
        bus.bg_addr   = '0;
`ifdef VRAM_ARB_DMA_EN
        bus.dma_req   = 1'b0;
        bus.dma_we    = 1'b0;
        bus.dma_addr  = '0;
        bus.dma_wdata = '0;
`endif
    endtask

    task automatic req(logic we, logic [15:0] addr, logic [15:0] wdata);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
    endtask

    // One clock: the model derives this cycle's expected outputs from the slot rules, then advances.
    task automatic cycle();
        logic        bgs, gnt, acc, ere, ewe, erv;
        logic [15:0] ea, ewd;
        bus.char_cycle = cc;
        @(negedge clock);
        bgs = bus.bg_active && bg_mask[cc];
        gnt = m_pend && !bgs;
        acc = bus.cpu_req && !m_pend;
        ea = 16'h0; ewd = 16'h0; ere = 1'b0; ewe = 1'b0;
        if (bgs) begin
            ea = bus.bg_addr; ere = 1'b1;
        end else if (gnt) begin
            ea = m_addr; ere = !m_we; ewe = m_we; ewd = m_wdata;
        end
        erv = (rq.size() > 0) && (rq[0].due == cyc);
        if (erv) begin
            m_rdata = rq[0].d;
            void'(rq.pop_front());
        end
        chk("vram_addr", bus.vram_addr, ea);
        chk("vram_re", bus.vram_re, ere);
        chk("vram_we", bus.vram_we, ewe);
        if (!bgs) chk("vram_wdata", bus.vram_wdata, ewd);
        chk("cpu_busy", bus.cpu_busy, m_pend);
        chk("cpu_ovf", bus.cpu_ovf, m_ovf);
        chk("cpu_rvalid", bus.cpu_rvalid, erv);
        chk("cpu_rdata", bus.cpu_rdata, m_rdata);
        last_addr = bus.vram_addr; last_re = bus.vram_re; last_we = bus.vram_we;
        last_wdata = bus.vram_wdata; last_rvalid = bus.cpu_rvalid; last_rdata = bus.cpu_rdata;
        last_ovf = bus.cpu_ovf; last_busy = bus.cpu_busy; last_cc = cc;
        if (bus.cpu_req && m_pend) m_ovf = 1'b1;
        if (gnt) begin
            if (m_we) ref_mem[m_addr] = m_wdata;
            else      rq.push_back('{due: cyc + 2, d: ref_mem[m_addr]});
            m_pend = 1'b0;
        end
        if (acc) begin
            m_pend = 1'b1; m_we = bus.cpu_we; m_addr = bus.cpu_addr; m_wdata = bus.cpu_wdata;
        end
        @(posedge clock);
        cyc++;
        cc++;
        #1;
        bus.cpu_req = 1'b0;
    endtask

    task automatic apply_reset(int n);
        reset = 1'b1;
        idle_in();
        m_pend = 1'b0; m_ovf = 1'b0; m_rdata = 16'h0;
        rq.delete();
        for (int i = 0; i < n; i++) begin
            bus.char_cycle = cc;
            @(negedge clock);
            chk("rst_addr", bus.vram_addr, 16'h0);
            chk("rst_re", bus.vram_re, 1'b0);
            chk("rst_we", bus.vram_we, 1'b0);
            chk("rst_wdata", bus.vram_wdata, 16'h0);
            chk("rst_busy", bus.cpu_busy, 1'b0);
            chk("rst_ovf", bus.cpu_ovf, 1'b0);
            chk("rst_rvalid", bus.cpu_rvalid, 1'b0);
            chk("rst_rdata", bus.cpu_rdata, 16'h0);
            @(posedge clock);
            cyc++;
            cc++;
            #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        int n, k, bad;
        for (int i = 0; i < 65536; i++) begin
            vmem[i]    = init_val(16'(i));
            ref_mem[i] = init_val(16'(i));
        end
        bus.char_cycle = 3'd0;
        idle_in();
        apply_reset(3);

        // Read with BG idle: grant one cycle after acceptance, data two cycles after grant.
        req(1'b0, 16'h1234, 16'h0);
        cycle();
        cycle();
        chk("t1_addr", last_addr, 16'h1234);
        chk("t1_re", last_re, 1'b1);
        cycle();
        cycle();
        chk("t1_rvalid", last_rvalid, 1'b1);
        chk("t1_rdata", last_rdata, init_val(16'h1234));

        // Write accepted at char_cycle 4 waits out the BG slot at 5 and issues at 6.
        while (cc != 3'd4) cycle();
        bus.bg_active = 1'b1;
        bus.bg_addr = 16'h7000;
        req(1'b1, 16'h0040, 16'hBEEF);
        cycle();
        bus.bg_addr = 16'hC0DE;
        cycle();
        chk("t2_bg_addr", last_addr, 16'hC0DE);
        chk("t2_bg_we", last_we, 1'b0);
        cycle();
        chk("t2_we", last_we, 1'b1);
        chk("t2_addr", last_addr, 16'h0040);
        chk("t2_wdata", last_wdata, 16'hBEEF);

        // Back-to-back requests under continuous BG fetch.
        n = 0; k = 0; bad = 0;
        while ((n < 20 || k < 24) && k < 200) begin
            bus.bg_active = 1'b1;
            bus.bg_addr = 16'($urandom);
            if (!m_pend && n < 20) begin
                req(1'($urandom), 16'h0300 + 16'($urandom % 8), 16'($urandom));
                n++;
            end
            cycle();
            if (bg_mask[last_cc] && last_we) bad++;
            k++;
        end
        chk("b2b_count", n, 20);
        chk("b2b_bg_slot_writes", bad, 0);
        chk("b2b_ovf", last_ovf, 1'b0);
        bus.bg_active = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        // Random traffic, requests only while the buffer is free.
        for (int i = 0; i < 400; i++) begin
            bus.bg_active = ($urandom % 4) != 0;
            bus.bg_addr = 16'($urandom);
            if (!m_pend && ($urandom % 2) == 1)
                req(1'($urandom), 16'h0100 + 16'($urandom % 16), 16'($urandom));
            cycle();
        end
        chk("rand_ovf_clear", last_ovf, 1'b0);

        // Request during PEND is dropped and sets the sticky overflow.
        bus.bg_active = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        req(1'b0, 16'h0555, 16'h0);
        cycle();
        req(1'b1, 16'h0555, 16'hDEAD);
        cycle();
        cycle();
        chk("ovf_set", last_ovf, 1'b1);
        cycle();
        chk("ovf_first_rvalid", last_rvalid, 1'b1);
        chk("ovf_first_rdata", last_rdata, init_val(16'h0555));

        // Random traffic ignoring busy; overflow must stay set.
        for (int i = 0; i < 200; i++) begin
            bus.bg_active = ($urandom % 3) != 0;
            bus.bg_addr = 16'($urandom);
            if (($urandom % 3) == 0)
                req(1'($urandom), 16'h0100 + 16'($urandom % 16), 16'($urandom));
            cycle();
        end
        chk("ovf_sticky", last_ovf, 1'b1);

        // Reset during G+1 of a read discards the return.
        bus.bg_active = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        req(1'b0, 16'h0200, 16'h0);
        cycle();
        cycle();
        chk("rst_g_re", last_re, 1'b1);
        apply_reset(2);
        for (int i = 0; i < 6; i++) cycle();
        chk("post_rst_busy", last_busy, 1'b0);
        chk("post_rst_ovf", last_ovf, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
